// File: rtl/ras_recur_ckpt_if.sv
// ras_recur_ckpt_if: predictor <-> return address stack bundle
// master (fetch predictor): drives push/pop/restore, reads top and checkpoint outputs
// slave (ras_recur_ckpt): consumes push/pop/restore, drives top_valid/top_target/ckpt_*
interface ras_recur_ckpt_if #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_TARGET_WIDTH = 31,
    parameter int RAS_RECUR_WIDTH  = 2
);
    localparam int LW = $clog2(RAS_ENTRIES);
    logic                        push_valid;
    logic [RAS_TARGET_WIDTH-1:0] push_target;
    logic                        pop_valid;
    logic                        top_valid;
    logic [RAS_TARGET_WIDTH-1:0] top_target;
    logic [LW-1:0]               ckpt_ptr;
    logic [LW:0]                 ckpt_count;
    logic [RAS_RECUR_WIDTH-1:0]  ckpt_recur;
    logic                        restore_valid;
    logic [LW-1:0]               restore_ptr;
    logic [LW:0]                 restore_count;
    logic [RAS_RECUR_WIDTH-1:0]  restore_recur;
    modport master (
        output push_valid, push_target, pop_valid, restore_valid, restore_ptr, restore_count, restore_recur,
        input  top_valid, top_target, ckpt_ptr, ckpt_count, ckpt_recur
    );
    modport slave (
        input  push_valid, push_target, pop_valid, restore_valid, restore_ptr, restore_count, restore_recur,
        output top_valid, top_target, ckpt_ptr, ckpt_count, ckpt_recur
    );
endinterface

// File: rtl/ras_recur_ckpt.sv
// ras_recur_ckpt: circular return address stack with per-entry recursion counters and checkpoint restore
// CLK, RST (async active-high); bus: ras_recur_ckpt_if.slave carrying push/pop/restore in, top/ckpt out
module ras_recur_ckpt #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_TARGET_WIDTH = 31,
    parameter int RAS_RECUR_WIDTH  = 2
) (
    input logic            CLK,
    input logic            RST,
    ras_recur_ckpt_if.slave bus
);
    localparam int LW = $clog2(RAS_ENTRIES);
    localparam logic [LW:0] FULL = (LW+1)'(RAS_ENTRIES);
    logic [RAS_TARGET_WIDTH-1:0] tgt [RAS_ENTRIES];
    logic [RAS_RECUR_WIDTH-1:0]  rec [RAS_ENTRIES];
    logic [LW-1:0]               ptr;
    logic [LW:0]                 count;
    logic [LW-1:0]               ptr_inc;
    logic                        match;
    assign ptr_inc        = ptr + 1'b1;
    // a repeated call to the current top shares its entry until the counter saturates
    assign match          = (count != '0) && (bus.push_target == tgt[ptr]) && !(&rec[ptr]);
    assign bus.top_valid  = count != '0;
    assign bus.top_target = tgt[ptr];
    assign bus.ckpt_ptr   = ptr;
    assign bus.ckpt_count = count;
    assign bus.ckpt_recur = rec[ptr];
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                tgt[i] <= '0;
                rec[i] <= '0;
            end
            ptr   <= '0;
            count <= '0;
        end else if (bus.restore_valid) begin
            ptr                   <= bus.restore_ptr;
            count                 <= bus.restore_count;
            rec[bus.restore_ptr]  <= bus.restore_recur;
        end else if (bus.push_valid && bus.pop_valid) begin
            // tail call: replace the top in place
            tgt[ptr] <= bus.push_target;
            rec[ptr] <= '0;
            if (count == '0) count <= 1'b1;
        end else if (bus.push_valid) begin
            if (match) begin
                rec[ptr] <= rec[ptr] + 1'b1;
            end else begin
                ptr          <= ptr_inc;
                tgt[ptr_inc] <= bus.push_target;
                rec[ptr_inc] <= '0;
                if (count != FULL) count <= count + 1'b1;
            end
        end else if (bus.pop_valid && count != '0) begin
            if (rec[ptr] != '0) begin
                rec[ptr] <= rec[ptr] - 1'b1;
            end else begin
                ptr   <= ptr - 1'b1;
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ras_recur_ckpt.sv
// tb_ras_recur_ckpt: scoreboard bench for ras_recur_ckpt (directed scenarios plus random run against a model)
module tb_ras_recur_ckpt;
    typedef enum int {K_TOP, K_VALID, K_PTR, K_CNT, K_REC} kind_t;
    typedef struct {kind_t k; logic [31:0] v;} exp_t;
    logic clk = 0;
    logic rst = 1;
    int n_cmp = 0;
    int n_err = 0;
    exp_t q[$];
    ras_recur_ckpt_if #(.RAS_ENTRIES(8), .RAS_TARGET_WIDTH(31), .RAS_RECUR_WIDTH(2)) bus ();
    ras_recur_ckpt #(.RAS_ENTRIES(8), .RAS_TARGET_WIDTH(31), .RAS_RECUR_WIDTH(2)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (!rst && bus.restore_valid)
        assert (bus.restore_count <= 4'd8) else $error("illegal restore_count %0d", bus.restore_count);
    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] obs(input kind_t k);
        return k == K_TOP ? 32'(bus.top_target) : k == K_VALID ? 32'(bus.top_valid) :
               k == K_PTR ? 32'(bus.ckpt_ptr) : k == K_CNT ? 32'(bus.ckpt_count) : 32'(bus.ckpt_recur);
    endfunction
    task automatic ex(input kind_t k, input logic [31:0] v);
        q.push_back('{k, v});
    endtask
    task automatic ex_st(input logic [31:0] t, input int v, input int p, input int c, input int r);
        ex(K_TOP, t); ex(K_VALID, 32'(v)); ex(K_PTR, 32'(p)); ex(K_CNT, 32'(c)); ex(K_REC, 32'(r));
    endtask
    task automatic drain();
        exp_t e;
        while (q.size() != 0) begin
            e = q.pop_front();
            chk(e.k.name(), obs(e.k), e.v);
        end
    endtask
    task automatic settle();
        #1;
        drain();
    endtask
    task automatic step(input logic pu, input logic [30:0] t, input logic po, input logic rv,
                        input logic [2:0] rp, input logic [3:0] rc, input logic [1:0] rr);
        bus.push_valid = pu; bus.push_target = t; bus.pop_valid = po;
        bus.restore_valid = rv; bus.restore_ptr = rp; bus.restore_count = rc; bus.restore_recur = rr;
        settle();
        @(posedge clk); #1;
        bus.push_valid = 0; bus.pop_valid = 0; bus.restore_valid = 0;
    endtask
    task automatic push(input logic [30:0] t); step(1, t, 0, 0, 0, 0, 0); endtask
    task automatic pop(); step(0, 0, 1, 0, 0, 0, 0); endtask
    task automatic do_reset();
        rst = 1;
        ex_st(0, 0, 0, 0, 0);
        settle();
        #2 rst = 0;
        @(posedge clk); #1;
    endtask
    logic [30:0] mt [8];
    logic [1:0]  mr [8];
    int mp, mc;
    initial begin
        bus.push_valid = 0; bus.push_target = 0; bus.pop_valid = 0;
        bus.restore_valid = 0; bus.restore_ptr = 0; bus.restore_count = 0; bus.restore_recur = 0;
        #1;
        do_reset();
        // basic push/pop
        push(31'h100); push(31'h200); push(31'h300);
        ex_st(31'h300, 1, 3, 3, 0);
        ex(K_TOP, 31'h300); pop();
        ex(K_TOP, 31'h200); pop();
        ex(K_TOP, 31'h100); pop();
        ex(K_VALID, 0); ex(K_CNT, 0); settle();
        // recursion counter sharing and saturation
        push(31'h40); ex(K_PTR, 1); ex(K_REC, 0);
        push(31'h40); push(31'h40); push(31'h40);
        ex(K_PTR, 1); ex(K_REC, 3); ex(K_CNT, 1);
        push(31'h40); ex(K_PTR, 2); ex(K_REC, 0); ex(K_CNT, 2);
        for (int i = 0; i < 5; i++) begin
            ex(K_TOP, 31'h40);
            pop();
        end
        ex(K_CNT, 0); ex(K_VALID, 0); settle();
        // overflow drops the oldest entry
        for (int i = 1; i <= 9; i++) push(31'(i));
        ex_st(31'h9, 1, 1, 8, 0);
        for (int i = 9; i >= 2; i--) begin
            ex(K_TOP, 31'(i));
            pop();
        end
        ex(K_CNT, 0); ex(K_VALID, 0); settle();
        // push and pop together
        do_reset();
        push(31'h10); push(31'h20);
        ex(K_TOP, 31'h20); step(1, 31'h30, 1, 0, 0, 0, 0);
        ex_st(31'h30, 1, 2, 2, 0); settle();
        // checkpoint and restore, push ignored
        do_reset();
        push(31'h10); push(31'h20);
        ex_st(31'h20, 1, 2, 2, 0);
        push(31'h30); push(31'h30);
        ex(K_REC, 1); ex(K_PTR, 3); pop();
        ex(K_REC, 0); ex(K_PTR, 3); ex(K_CNT, 3);
        step(1, 31'h50, 0, 1, 3'd2, 4'd2, 2'd0);
        ex_st(31'h20, 1, 2, 2, 0);
        push(31'h20);
        ex(K_REC, 1); ex(K_PTR, 2); settle();
        // restore to empty, pop on empty, async reset mid-push
        step(0, 0, 0, 1, 3'd0, 4'd0, 2'd0);
        ex(K_VALID, 0); ex(K_CNT, 0); ex(K_PTR, 0);
        pop();
        ex(K_VALID, 0); ex(K_CNT, 0); ex(K_PTR, 0);
        push(31'h80);
        ex_st(31'h80, 1, 1, 1, 0); settle();
        bus.push_valid = 1; bus.push_target = 31'h70;
        #1 rst = 1;
        ex_st(0, 0, 0, 0, 0); settle();
        bus.push_valid = 0;
        #1 rst = 0;
        @(posedge clk); #1;
        ex_st(0, 0, 0, 0, 0);
        push(31'h90);
        ex_st(31'h90, 1, 1, 1, 0); settle();
        // random traffic against a reference model
        do_reset();
        for (int i = 0; i < 8; i++) begin mt[i] = 0; mr[i] = 0; end
        mp = 0; mc = 0;
        for (int n = 0; n < 400; n++) begin
            logic pu, po, rv;
            logic [30:0] t;
            logic [2:0] rp;
            logic [3:0] rc;
            logic [1:0] rr;
            pu = 1'($urandom_range(0, 1)); po = 1'($urandom_range(0, 1));
            rv = $urandom_range(0, 15) == 0;
            t = 31'($urandom_range(1, 3));
            rp = 3'($urandom_range(0, 7)); rc = 4'($urandom_range(0, 8)); rr = 2'($urandom_range(0, 3));
            ex_st(32'(mt[mp]), int'(mc != 0), mp, mc, int'(mr[mp]));
            step(pu, t, po, rv, rp, rc, rr);
            if (rv) begin
                mp = int'(rp); mc = int'(rc); mr[rp] = rr;
            end else if (pu && po) begin
                mt[mp] = t; mr[mp] = 0;
                if (mc == 0) mc = 1;
            end else if (pu) begin
                if (mc != 0 && t == mt[mp] && mr[mp] != 2'd3) mr[mp] = mr[mp] + 2'd1;
                else begin
                    mp = (mp + 1) % 8; mt[mp] = t; mr[mp] = 0;
                    if (mc < 8) mc++;
                end
            end else if (po && mc != 0) begin
                if (mr[mp] != 0) mr[mp] = mr[mp] - 2'd1;
                else begin
                    mp = (mp + 7) % 8; mc--;
                end
            end
        end
        ex_st(32'(mt[mp]), int'(mc != 0), mp, mc, int'(mr[mp])); settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
